// File: rtl/pico_bus_pkg.sv
// Shared encodings and output decode for the pico_data bus sequencer.
package pico_bus_pkg;

    localparam int CW_DEFAULT = 10;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_DATA = 2'b10,
        OP_EXEC    = 2'b11
    } host_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_CAM
    } state_e;

    typedef struct packed {
        logic host_done;
        logic rd_sample;
        logic cam_grant;
        logic sel_poc;
        logic sel_sod;
        logic direction;
        logic simd_cs;
        logic simd_wr;
        logic simd_rd;
        logic simd_cd;
        logic simd_exec;
        logic busy;
    } bus_out_t;

    // last: the phase timer reaches zero in state s
    function automatic bus_out_t decode(
        input state_e   s,
        input host_op_e op,
        input logic     last,
        input logic     no_hold
    );
        bus_out_t o;
        logic     is_rd;
        o     = '0;
        is_rd = (op == OP_RD_DATA);
        o.busy = (s != ST_IDLE);
        unique case (1'b1)
            (s == ST_CAM): begin
                o.cam_grant = 1'b1;
                o.sel_poc   = 1'b1;
            end
            (s == ST_SETUP),
            (s == ST_STROBE),
            (s == ST_HOLD): begin
                o.simd_cs   = 1'b1;
                o.simd_cd   = (op == OP_WR_ADDR);
                o.sel_sod   = is_rd;
                o.direction = is_rd;
                if (s == ST_STROBE) begin
                    o.simd_wr   = (op == OP_WR_ADDR) || (op == OP_WR_DATA);
                    o.simd_rd   = is_rd;
                    o.simd_exec = (op == OP_EXEC);
                    o.rd_sample = is_rd && last;
                    o.host_done = no_hold && last;
                end
                if (s == ST_HOLD) begin
                    o.host_done = last;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pico_bus_sequencer_phase_timer.sv
// Loadable down-counter with zero flags; times every sequencer phase.
module phase_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero,
    output logic          zero_next
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero      = (cnt == '0);
    assign zero_next = load ? (load_val == '0) : (cnt <= CW'(1));

endmodule

// File: rtl/pico_bus_sequencer.sv
// Host/camera arbiter and SIMD strobe sequencer for the pico_data bus.
// Optional BUS_WATCHDOG_EN adds a starvation watchdog and the wd_trip port.
module pico_bus_sequencer
    import pico_bus_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int STRB_CYC  = 3,
    parameter int HOLD_CYC  = 1,
    parameter int MAX_BURST = 640,
    parameter int CW        = CW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    input  logic [1:0] host_op,
    output logic       host_ready,
    output logic       host_done,
    output logic       rd_sample,
    input  logic       cam_req,
    output logic       cam_grant,
    output logic       sel_poc,
    output logic       sel_sod,
    output logic       direction,
    output logic       simd_cs,
    output logic       simd_wr,
    output logic       simd_rd,
    output logic       simd_cd,
    output logic       simd_exec,
`ifdef BUS_WATCHDOG_EN
    output logic       wd_trip,
`endif
    output logic       busy
);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_STRB  = CW'(STRB_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] LD_CAM   = CW'(MAX_BURST - 1);
    localparam logic          NO_HOLD  = (HOLD_CYC == 0);

    state_e        state, state_n;
    host_op_e      op, op_n;
    logic          last_host, last_host_n;
    logic          grant_cam, accept;
    logic          load, zero, zero_n;
    logic [CW-1:0] load_val;
    logic          wd_hit, wd_force;
    bus_out_t      outs;

`ifdef BUS_WATCHDOG_EN
    logic [CW-1:0] wd_cnt;

    assign wd_hit = (state == ST_CAM) && host_valid && (wd_cnt == LD_CAM);

    // Unserved host cycles accumulate across bursts until the host is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= '0;
            wd_force <= 1'b0;
            wd_trip  <= 1'b0;
        end else begin
            wd_trip <= wd_hit;
            if (accept) begin
                wd_cnt   <= '0;
                wd_force <= 1'b0;
            end else if (wd_hit) begin
                wd_cnt   <= '0;
                wd_force <= 1'b1;
            end else if (state == ST_CAM && host_valid) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
        end
    end
`else
    assign wd_hit   = 1'b0;
    assign wd_force = 1'b0;
`endif

    assign grant_cam  = cam_req & (~host_valid | (last_host & ~wd_force));
    assign accept     = (state == ST_IDLE) & host_valid & ~grant_cam;
    assign host_ready = accept;

    always_comb begin
        state_n     = state;
        op_n        = op;
        last_host_n = last_host;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n     = ST_SETUP;
                    op_n        = host_op_e'(host_op);
                    last_host_n = 1'b1;
                end else if (grant_cam) begin
                    state_n     = ST_CAM;
                    last_host_n = 1'b0;
                end
            end
            ST_SETUP: if (zero) state_n = ST_STROBE;
            ST_STROBE: if (zero) state_n = NO_HOLD ? ST_IDLE : ST_HOLD;
            ST_HOLD: if (zero) state_n = ST_IDLE;
            ST_CAM: if (!cam_req || zero || wd_hit) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        load = (state_n != state);
        unique case (state_n)
            ST_SETUP:  load_val = LD_SETUP;
            ST_STROBE: load_val = LD_STRB;
            ST_HOLD:   load_val = LD_HOLD;
            ST_CAM:    load_val = LD_CAM;
            default:   load_val = '0;
        endcase
    end

    phase_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .zero      (zero),
        .zero_next (zero_n)
    );

    // Outputs are decoded from the next state so they register with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op        <= OP_WR_ADDR;
            last_host <= 1'b0;
            outs      <= '0;
        end else begin
            state     <= state_n;
            op        <= op_n;
            last_host <= last_host_n;
            outs      <= decode(state_n, op_n, zero_n, NO_HOLD);
        end
    end

    assign host_done = outs.host_done;
    assign rd_sample = outs.rd_sample;
    assign cam_grant = outs.cam_grant;
    assign sel_poc   = outs.sel_poc;
    assign sel_sod   = outs.sel_sod;
    assign direction = outs.direction;
    assign simd_cs   = outs.simd_cs;
    assign simd_wr   = outs.simd_wr;
    assign simd_rd   = outs.simd_rd;
    assign simd_cd   = outs.simd_cd;
    assign simd_exec = outs.simd_exec;
    assign busy      = outs.busy;

endmodule

// File: tb/tb_pico_bus_sequencer.sv
// Self-checking bench: cycle-offset reference model plus directed literal checks.
module tb_pico_bus_sequencer;

    localparam int S  = 2;
    localparam int T  = 3;
    localparam int H  = 1;
    localparam int MB = 640;
    localparam int N  = S + T + H;

    logic clk = 1'b0;
    logic rst, host_valid, cam_req;
    logic [1:0] host_op;

    logic host_ready, host_done, rd_sample, cam_grant, sel_poc, sel_sod;
    logic direction, simd_cs, simd_wr, simd_rd, simd_cd, simd_exec, busy;
    logic z_ready, z_done, z_rs, z_cg, z_poc, z_sod, z_dir;
    logic z_cs, z_wr, z_rd, z_cd, z_exec, z_busy;
`ifdef BUS_WATCHDOG_EN
    logic wd_trip, z_wd_trip;
`endif

    always #5 clk = ~clk;

    pico_bus_sequencer dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_op(host_op),
        .host_ready(host_ready), .host_done(host_done), .rd_sample(rd_sample),
        .cam_req(cam_req), .cam_grant(cam_grant), .sel_poc(sel_poc),
        .sel_sod(sel_sod), .direction(direction), .simd_cs(simd_cs),
        .simd_wr(simd_wr), .simd_rd(simd_rd), .simd_cd(simd_cd),
        .simd_exec(simd_exec),
`ifdef BUS_WATCHDOG_EN
        .wd_trip(wd_trip),
`endif
        .busy(busy)
    );

    pico_bus_sequencer #(.HOLD_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_op(host_op),
        .host_ready(z_ready), .host_done(z_done), .rd_sample(z_rs),
        .cam_req(cam_req), .cam_grant(z_cg), .sel_poc(z_poc),
        .sel_sod(z_sod), .direction(z_dir), .simd_cs(z_cs),
        .simd_wr(z_wr), .simd_rd(z_rd), .simd_cd(z_cd),
        .simd_exec(z_exec),
`ifdef BUS_WATCHDOG_EN
        .wd_trip(z_wd_trip),
`endif
        .busy(z_busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: active host op with cycle offset m_d, or camera burst at cycle m_j.
    bit       m_h, m_c, m_last;
    int       m_d, m_j;
    logic [1:0] m_op;

    logic [11:0] o_vec;
    logic        o_hr;
    logic [2:0]  o_z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_vec();
        logic st;
        st = m_h && m_d >= S && m_d < S + T;
        return {m_h && m_d == N - 1,
                st && m_op == 2'd2 && m_d == S + T - 1,
                m_c, m_c,
                m_h && m_op == 2'd2, m_h && m_op == 2'd2,
                m_h,
                st && m_op < 2'd2,
                st && m_op == 2'd2,
                m_h && m_op == 2'd0,
                st && m_op == 2'd3,
                m_h || m_c};
    endfunction

    task automatic step();
        logic gc, exp_hr;
        logic [11:0] act_v;
        #1;
        act_v = {host_done, rd_sample, cam_grant, sel_poc, sel_sod, direction,
                 simd_cs, simd_wr, simd_rd, simd_cd, simd_exec, busy};
        chk("outputs", act_v, model_vec());
        gc     = cam_req & (~host_valid | m_last);
        exp_hr = !m_h && !m_c && host_valid && !gc;
        chk("host_ready", host_ready, exp_hr);
        o_vec = act_v;
        o_hr  = host_ready;
        o_z   = {z_exec, z_done, z_busy};
        if (rst) begin
            m_h = 0; m_c = 0; m_last = 0;
        end else if (m_h) begin
            if (m_d == N - 1) m_h = 0;
            else m_d++;
        end else if (m_c) begin
            if (!cam_req || m_j == MB - 1) m_c = 0;
            else m_j++;
        end else if (exp_hr) begin
            m_h = 1; m_d = 0; m_op = host_op; m_last = 1;
        end else if (gc) begin
            m_c = 1; m_j = 0; m_last = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; host_valid = 1'b0; cam_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [15:0] m_a, m_b, m_c2, m_e;
    int first_len, ready_at, done_cnt;
    logic g649, wr4;
    logic [11:0] v5;

    initial begin
        rst = 1'b1; host_valid = 1'b0; cam_req = 1'b0; host_op = 2'd0;
        m_h = 0; m_c = 0; m_last = 0; m_d = 0; m_j = 0; m_op = 2'd0;
        @(negedge clk);
        chk("reset outputs", {host_done, rd_sample, cam_grant, sel_poc, sel_sod,
            direction, simd_cs, simd_wr, simd_rd, simd_cd, simd_exec, busy}, 12'h000);
        do_reset();

        // WR_ADDR timing
        host_valid = 1'b1; host_op = 2'd0; step(); host_valid = 1'b0;
        m_a = 0; m_b = 0; m_c2 = 0; m_e = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            m_a[i-1] = o_vec[5]; m_b[i-1] = o_vec[4];
            m_c2[i-1] = o_vec[2]; m_e[i-1] = o_vec[11];
        end
        chk("wr_addr cs", m_a, 16'h3F);
        chk("wr_addr wr", m_b, 16'h1C);
        chk("wr_addr cd", m_c2, 16'h3F);
        chk("wr_addr done", m_e, 16'h20);

        // RD_DATA selects and sample point
        host_valid = 1'b1; host_op = 2'd2; step(); host_valid = 1'b0;
        m_a = 0; m_b = 0; m_c2 = 0; m_e = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            m_a[i-1] = o_vec[6]; m_b[i-1] = o_vec[7];
            m_c2[i-1] = o_vec[3]; m_e[i-1] = o_vec[10];
        end
        chk("rd direction", m_a, 16'h3F);
        chk("rd sel_sod", m_b, 16'h3F);
        chk("rd strobe", m_c2, 16'h1C);
        chk("rd_sample", m_e, 16'h10);

        // Fairness: host first after reset, then camera, then host
        do_reset();
        host_valid = 1'b1; host_op = 2'd1; cam_req = 1'b1;
        m_a = 0; m_b = 0;
        for (int s = 0; s < 12; s++) begin
            if (s == 10) cam_req = 1'b0;
            step();
            m_a[s] = o_hr; m_b[s] = o_vec[9];
        end
        host_valid = 1'b0;
        repeat (8) step();
        chk("fair host_ready", m_a, 16'h801);
        chk("fair cam_grant", m_b, 16'h700);

        // Burst limit with cam_req held
        do_reset();
        cam_req = 1'b1; first_len = 0; ready_at = -1; g649 = 1'b0;
        for (int s = 0; s < 1000; s++) begin
            if (s == 5) begin host_valid = 1'b1; host_op = 2'd2; end
            step();
            if (o_hr) host_valid = 1'b0;
            if (o_vec[9] && ready_at < 0) first_len++;
            if (o_hr && ready_at < 0) ready_at = s;
            if (s == 649) g649 = o_vec[9];
        end
        cam_req = 1'b0;
        repeat (3) step();
        chk("burst length", first_len, 640);
        chk("host after burst", ready_at, 641);
        chk("cam regrant", g649, 1'b1);

        // Reset in the middle of a strobe
        do_reset();
        host_valid = 1'b1; host_op = 2'd0; step(); host_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1; step(); wr4 = o_vec[4]; rst = 1'b0;
        step(); v5 = o_vec;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_vec[11]) done_cnt++;
        end
        chk("strobe before rst", wr4, 1'b1);
        chk("outputs after rst", v5, 12'h000);
        chk("no done after rst", done_cnt, 0);
        host_valid = 1'b1; host_op = 2'd1; step(); host_valid = 1'b0;
        m_a = 0; m_b = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            m_a[i-1] = o_vec[5]; m_b[i-1] = o_vec[4];
        end
        chk("post rst cs", m_a, 16'h3F);
        chk("post rst wr", m_b, 16'h1C);

        // EXEC with no hold phase
        do_reset();
        host_valid = 1'b1; host_op = 2'd3; step(); host_valid = 1'b0;
        m_a = 0; m_b = 0; m_c2 = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            m_a[i-1] = o_z[2]; m_b[i-1] = o_z[1]; m_c2[i-1] = o_z[0];
        end
        chk("nohold exec", m_a, 16'h1C);
        chk("nohold done", m_b, 16'h10);
        chk("nohold busy", m_c2, 16'h1F);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            host_valid = $urandom_range(0, 1) == 1;
            host_op    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) cam_req = ~cam_req;
            step();
        end
        rst = 1'b0; host_valid = 1'b0; cam_req = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
